// File: rtl/sbc09_wait_pkg.sv
// Shared encodings for the SBC09 wait-state generator: access classes, FSM states,
// E/Q phase codes, wait-state register offsets and class/count helpers.
package sbc09_wait_pkg;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_RAM   = 3'd1,
        CLS_ROM   = 3'd2,
        CLS_EXT   = 3'd3,
        CLS_EXTIO = 3'd4
    } wait_class_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_XWAIT = 2'd2;

    localparam logic [1:0] PH_EHI_START = 2'b11;
    localparam logic [1:0] PH_EHI_LATE  = 2'b01;
    localparam logic [1:0] PH_IDLE      = 2'b00;

    localparam logic [15:0] WS_LO_OFS = 16'd0;
    localparam logic [15:0] WS_HI_OFS = 16'd1;

    // Chip selects are active low; a granted bus (BA=1) never stalls.
    function automatic wait_class_e decode_class(
        input logic ba,
        input logic n_rom0,
        input logic n_rom1,
        input logic n_ram,
        input logic n_ext,
        input logic n_extio
    );
        wait_class_e c;
        if (ba)                     c = CLS_NONE;
        else if (!n_extio)          c = CLS_EXTIO;
        else if (!n_ext)            c = CLS_EXT;
        else if (!n_rom0 || !n_rom1) c = CLS_ROM;
        else if (!n_ram)            c = CLS_RAM;
        else                        c = CLS_NONE;
        return c;
    endfunction

    function automatic logic [3:0] ws_select(
        input wait_class_e c,
        input logic [7:0]  ws_lo,
        input logic [7:0]  ws_hi
    );
        logic [3:0] n;
        case (c)
            CLS_RAM:   n = ws_lo[3:0];
            CLS_ROM:   n = ws_lo[7:4];
            CLS_EXT:   n = ws_hi[3:0];
            CLS_EXTIO: n = ws_hi[7:4];
            default:   n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bus_wait_gen_sync2.sv
// Two-flop synchroniser for the asynchronous nWAIT request; resets to the idle (high)
// level. Only built when SBC09_EXT_WAIT_EN is defined.
`ifdef SBC09_EXT_WAIT_EN
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`endif

// File: rtl/bus_wait_gen.sv
// Wait-state generator feeding MRDY to the E/Q clock generator, with CPU-programmable
// per-class counts. Define SBC09_EXT_WAIT_EN to honour the expansion-bus nWAIT request.
module bus_wait_gen
    import sbc09_wait_pkg::*;
#(
    parameter logic [15:0] WAIT_BASE    = 16'hFE26,
    parameter logic [3:0]  WS_RAM_RST   = 4'd0,
    parameter logic [3:0]  WS_ROM_RST   = 4'd1,
    parameter logic [3:0]  WS_EXT_RST   = 4'd3,
    parameter logic [3:0]  WS_EXTIO_RST = 4'd3,
    parameter logic [7:0]  TIMEOUT      = 8'd255
) (
    input  logic        CLKX4,
    input  logic        nRESET,
    input  logic        QX,
    input  logic        EX,
    input  logic [15:0] ADDR,
    input  logic [7:0]  DATA_in,
    input  logic        RnW,
    input  logic        BA,
    input  logic        nCSROM0,
    input  logic        nCSROM1,
    input  logic        nCSRAM,
    input  logic        nCSEXT,
    input  logic        nCSEXTIO,
    input  logic        nWAIT,
    output logic        MRDY,
    output logic        WAIT_TO
);

    logic [1:0]  phase;
    wait_class_e cls_now;
    logic [3:0]  n_now;
    logic        wr_lo;
    logic        wr_hi;

    logic [7:0]  ws_lo_q;
    logic [7:0]  ws_hi_q;
    logic [1:0]  st_q, st_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mrdy_q, mrdy_d;

    assign phase   = {QX, EX};
    assign cls_now = decode_class(BA, nCSROM0, nCSROM1, nCSRAM, nCSEXT, nCSEXTIO);
    assign n_now   = ws_select(cls_now, ws_lo_q, ws_hi_q);

    // Writes land in the late E-high phase, after this cycle's count was latched.
    assign wr_lo = (phase == PH_EHI_LATE) && !RnW && !BA && (ADDR == (WAIT_BASE + WS_LO_OFS));
    assign wr_hi = (phase == PH_EHI_LATE) && !RnW && !BA && (ADDR == (WAIT_BASE + WS_HI_OFS));

`ifdef SBC09_EXT_WAIT_EN
    logic       nwait_s;
    logic [7:0] tmo_q, tmo_d;
    logic       ext_q, ext_d;
    logic       wto_q, wto_d;

    sync2 u_sync_nwait (
        .clk_i  (CLKX4),
        .rst_ni (nRESET),
        .d_i    (nWAIT),
        .q_o    (nwait_s)
    );

    assign WAIT_TO = wto_q;
`else
    logic unused_ext_wait;
    assign unused_ext_wait = nWAIT ^ (|TIMEOUT);
    assign WAIT_TO = 1'b0;
`endif

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        mrdy_d = mrdy_q;
`ifdef SBC09_EXT_WAIT_EN
        tmo_d  = tmo_q;
        ext_d  = ext_q;
        wto_d  = wto_q & ~wr_hi;
`endif
        case (st_q)
            ST_IDLE: begin
                mrdy_d = 1'b1;
                if ((phase == PH_EHI_START) && (n_now != 4'd0)) begin
                    mrdy_d = 1'b0;
                    cnt_d  = n_now;
                    st_d   = ST_COUNT;
`ifdef SBC09_EXT_WAIT_EN
                    ext_d  = (cls_now == CLS_EXT) || (cls_now == CLS_EXTIO);
`endif
                end
            end
            ST_COUNT: begin
                if (phase == PH_IDLE) begin
                    mrdy_d = 1'b1;
                    cnt_d  = 4'd0;
                    st_d   = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    cnt_d = 4'd0;
`ifdef SBC09_EXT_WAIT_EN
                    if (ext_q && !nwait_s) begin
                        tmo_d = 8'd0;
                        st_d  = ST_XWAIT;
                    end else begin
                        mrdy_d = 1'b1;
                        st_d   = ST_IDLE;
                    end
`else
                    mrdy_d = 1'b1;
                    st_d   = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_XWAIT: begin
`ifdef SBC09_EXT_WAIT_EN
                if ((phase == PH_IDLE) || nwait_s) begin
                    mrdy_d = 1'b1;
                    st_d   = ST_IDLE;
                end else if (tmo_q == TIMEOUT) begin
                    // Timeout set overrides a same-edge WS_HI clear.
                    mrdy_d = 1'b1;
                    wto_d  = 1'b1;
                    st_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`else
                mrdy_d = 1'b1;
                st_d   = ST_IDLE;
`endif
            end
            default: begin
                mrdy_d = 1'b1;
                cnt_d  = 4'd0;
                st_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            st_q    <= ST_IDLE;
            cnt_q   <= 4'd0;
            mrdy_q  <= 1'b1;
            ws_lo_q <= {WS_ROM_RST, WS_RAM_RST};
            ws_hi_q <= {WS_EXTIO_RST, WS_EXT_RST};
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            mrdy_q <= mrdy_d;
            if (wr_lo) ws_lo_q <= DATA_in;
            if (wr_hi) ws_hi_q <= DATA_in;
        end
    end

`ifdef SBC09_EXT_WAIT_EN
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            tmo_q <= 8'd0;
            ext_q <= 1'b0;
            wto_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            ext_q <= ext_d;
            wto_q <= wto_d;
        end
    end
`endif

    assign MRDY = mrdy_q;

endmodule

// File: tb/tb_bus_wait_gen.sv
// Scoreboard bench for bus_wait_gen: a behavioural E/Q generator stalls on MRDY, the driver
// queues expected stall/E-high lengths per bus cycle and a monitor checks each E-high.
module tb_bus_wait_gen;

    logic        CLKX4 = 1'b0;
    logic        nRESET = 1'b0;
    logic        QX, EX;
    logic [15:0] ADDR = 16'h0000;
    logic [7:0]  DATA_in = 8'h00;
    logic        RnW = 1'b1;
    logic        BA = 1'b0;
    logic        nCSROM0 = 1'b1, nCSROM1 = 1'b1, nCSRAM = 1'b1, nCSEXT = 1'b1, nCSEXTIO = 1'b1;
    logic        nWAIT = 1'b1;
    logic        MRDY, WAIT_TO;

    logic        gen_skip = 1'b0;
    int          drv_id = 0;
    int          next_id = 1;
    int          n_chk = 0;
    int          n_bad = 0;

    int          id_q[$];
    int          low_q[$];
    int          ehi_q[$];
    string       name_q[$];

`ifdef SBC09_EXT_WAIT_EN
    localparam int   EXT_STUCK_LOW = 5 + 255 + 1;
    localparam logic EXP_WTO       = 1'b1;
`else
    localparam int   EXT_STUCK_LOW = 5;
    localparam logic EXP_WTO       = 1'b0;
`endif

    localparam logic [4:0] CS_NONE  = 5'b00000;
    localparam logic [4:0] CS_ROM0  = 5'b00001;
    localparam logic [4:0] CS_ROM1  = 5'b00010;
    localparam logic [4:0] CS_RAM   = 5'b00100;
    localparam logic [4:0] CS_EXT   = 5'b01000;
    localparam logic [4:0] CS_EXTIO = 5'b10000;

    bus_wait_gen dut (
        .CLKX4    (CLKX4),
        .nRESET   (nRESET),
        .QX       (QX),
        .EX       (EX),
        .ADDR     (ADDR),
        .DATA_in  (DATA_in),
        .RnW      (RnW),
        .BA       (BA),
        .nCSROM0  (nCSROM0),
        .nCSROM1  (nCSROM1),
        .nCSRAM   (nCSRAM),
        .nCSEXT   (nCSEXT),
        .nCSEXTIO (nCSEXTIO),
        .nWAIT    (nWAIT),
        .MRDY     (MRDY),
        .WAIT_TO  (WAIT_TO)
    );

    always #5 CLKX4 = ~CLKX4;

    // E/Q generator: 00 -> 10 -> 11 -> 01 -> 00, holding 01 while MRDY is low.
    always @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            {QX, EX} <= 2'b00;
        end else begin
            case ({QX, EX})
                2'b00:   {QX, EX} <= 2'b10;
                2'b10:   {QX, EX} <= 2'b11;
                2'b11:   {QX, EX} <= gen_skip ? 2'b00 : 2'b01;
                default: {QX, EX} <= MRDY ? 2'b00 : 2'b01;
            endcase
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ph00();
        int k;
        k = 0;
        do begin
            @(negedge CLKX4);
            k++;
        end while (({QX, EX} != 2'b00) && (k < 600));
        if ({QX, EX} != 2'b00) begin
            n_chk++;
            n_bad++;
            $display("FAIL phase_wait: no E-low phase within %0d clocks", k);
        end
    endtask

    task automatic set_bus(input logic [4:0] cs, input logic ba, input logic rnw,
                           input logic [15:0] addr, input logic [7:0] data);
        nCSROM0  = ~cs[0];
        nCSROM1  = ~cs[1];
        nCSRAM   = ~cs[2];
        nCSEXT   = ~cs[3];
        nCSEXTIO = ~cs[4];
        BA       = ba;
        RnW      = rnw;
        ADDR     = addr;
        DATA_in  = data;
    endtask

    // Issues one bus cycle starting at the next E-low phase and queues its expectation.
    task automatic bus_cycle(input string nm, input logic [4:0] cs, input logic ba,
                             input logic rnw, input logic [15:0] addr, input logic [7:0] data,
                             input logic skip, input int exp_low, input int exp_ehi);
        wait_ph00();
        set_bus(cs, ba, rnw, addr, data);
        gen_skip = skip;
        drv_id   = next_id;
        id_q.push_back(next_id);
        low_q.push_back(exp_low);
        ehi_q.push_back(exp_ehi);
        name_q.push_back(nm);
        next_id++;
    endtask

    task automatic bus_idle();
        wait_ph00();
        set_bus(CS_NONE, 1'b0, 1'b1, 16'h0000, 8'h00);
        gen_skip = 1'b0;
        drv_id   = 0;
    endtask

    // Monitor: measures each E-high run and compares it against the queued expectation.
    int   m_ehi = 0;
    int   m_low = 0;
    int   m_id  = 0;
    logic m_prev_ex = 1'b0;

    initial begin
        forever begin
            @(negedge CLKX4);
            if (!nRESET) begin
                m_ehi = 0;
                m_low = 0;
                m_id  = 0;
                m_prev_ex = 1'b0;
            end else begin
                if (EX) begin
                    if (QX && !m_prev_ex) m_id = drv_id;
                    m_ehi++;
                    if (!MRDY) m_low++;
                end else if (m_prev_ex) begin
                    if (m_id != 0) begin
                        if (id_q.size() == 0) begin
                            n_chk++;
                            n_bad++;
                            $display("FAIL sb_underflow: cycle %0d had no expectation", m_id);
                        end else begin
                            string nm;
                            int    eid, elow, eehi;
                            eid  = id_q.pop_front();
                            elow = low_q.pop_front();
                            eehi = ehi_q.pop_front();
                            nm   = name_q.pop_front();
                            check({nm, "_id"}, m_id, eid);
                            check({nm, "_mrdy_low"}, m_low, elow);
                            check({nm, "_e_high"}, m_ehi, eehi);
                        end
                    end
                    m_ehi = 0;
                    m_low = 0;
                    m_id  = 0;
                end
                m_prev_ex = EX;
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLKX4);
        check("reset_mrdy", int'(MRDY), 1);
        check("reset_wait_to", int'(WAIT_TO), 0);
        #1 nRESET = 1'b1;

        // Reset defaults: RAM 0, ROM 1, EXT 3, EXTIO 3
        bus_cycle("ram_default",   CS_RAM,   1'b0, 1'b1, 16'h1000, 8'h00, 1'b0, 0, 2);
        bus_cycle("no_cs",         CS_NONE,  1'b0, 1'b1, 16'h1000, 8'h00, 1'b0, 0, 2);
        bus_cycle("rom0_default",  CS_ROM0,  1'b0, 1'b1, 16'hE000, 8'h00, 1'b0, 1, 3);
        bus_cycle("rom1_default",  CS_ROM1,  1'b0, 1'b1, 16'hF000, 8'h00, 1'b0, 1, 3);
        bus_cycle("extio_default", CS_EXTIO, 1'b0, 1'b1, 16'hFC00, 8'h00, 1'b0, 3, 5);

        // WS_HI = F5: EXTIO 15, EXT 5
        bus_cycle("wr_hi_f5",      CS_NONE,  1'b0, 1'b0, 16'hFE27, 8'hF5, 1'b0, 0, 2);
        bus_cycle("extio_15",      CS_EXTIO, 1'b0, 1'b1, 16'hFC00, 8'h00, 1'b0, 15, 17);
        bus_cycle("ext_5",         CS_EXT,   1'b0, 1'b1, 16'hC000, 8'h00, 1'b0, 5, 7);
        bus_cycle("prio_all",      5'b11111, 1'b0, 1'b1, 16'hC000, 8'h00, 1'b0, 15, 17);
        bus_cycle("prio_ext_rom",  5'b01101, 1'b0, 1'b1, 16'hC000, 8'h00, 1'b0, 5, 7);

        // WS_LO = 20 then 13
        bus_cycle("wr_lo_20",      CS_NONE,  1'b0, 1'b0, 16'hFE26, 8'h20, 1'b0, 0, 2);
        bus_cycle("rom_2",         CS_ROM0,  1'b0, 1'b1, 16'hE000, 8'h00, 1'b0, 2, 4);
        bus_cycle("ram_0",         CS_RAM,   1'b0, 1'b1, 16'h2000, 8'h00, 1'b0, 0, 2);
        bus_cycle("wr_lo_13",      CS_NONE,  1'b0, 1'b0, 16'hFE26, 8'h13, 1'b0, 0, 2);
        bus_cycle("ram_3",         CS_RAM,   1'b0, 1'b1, 16'h2000, 8'h00, 1'b0, 3, 5);
        bus_cycle("prio_rom_ram",  5'b00110, 1'b0, 1'b1, 16'h2000, 8'h00, 1'b0, 1, 3);

        // Bus granted or read cycles never stall and never write
        bus_cycle("ba_ext",        CS_EXT,   1'b1, 1'b1, 16'hC000, 8'h00, 1'b0, 0, 2);
        bus_cycle("ba_wr_lo",      CS_NONE,  1'b1, 1'b0, 16'hFE26, 8'hFF, 1'b0, 0, 2);
        bus_cycle("rd_lo",         CS_NONE,  1'b0, 1'b1, 16'hFE26, 8'hEE, 1'b0, 0, 2);
        bus_cycle("ram_still_3",   CS_RAM,   1'b0, 1'b1, 16'h2000, 8'h00, 1'b0, 3, 5);
        bus_cycle("rom_still_1",   CS_ROM1,  1'b0, 1'b1, 16'hF000, 8'h00, 1'b0, 1, 3);

        // nWAIT stuck low during an EXT access
        bus_cycle("ext_nwait_low", CS_EXT,   1'b0, 1'b1, 16'hC000, 8'h00, 1'b0,
                  EXT_STUCK_LOW, EXT_STUCK_LOW + 2);
        nWAIT = 1'b0;
        bus_idle();
        nWAIT = 1'b1;
        check("wait_to_after_stuck", int'(WAIT_TO), int'(EXP_WTO));
        bus_cycle("wr_hi_clear",   CS_NONE,  1'b0, 1'b0, 16'hFE27, 8'hF5, 1'b0, 0, 2);
        bus_idle();
        check("wait_to_cleared", int'(WAIT_TO), 0);

        // A write inside a stalled cycle only affects later cycles
        bus_cycle("extio_wr_same", CS_EXTIO, 1'b0, 1'b0, 16'hFE27, 8'h72, 1'b0, 15, 17);
        bus_cycle("extio_7",       CS_EXTIO, 1'b0, 1'b1, 16'hFC00, 8'h00, 1'b0, 7, 9);
        bus_cycle("ext_2",         CS_EXT,   1'b0, 1'b1, 16'hC000, 8'h00, 1'b0, 2, 4);

        // Generator skips the late E-high phase; FSM must recover
        bus_cycle("rom_skip01",    CS_ROM0,  1'b0, 1'b1, 16'hE000, 8'h00, 1'b1, 0, 1);
        bus_cycle("rom_after_skip", CS_ROM0, 1'b0, 1'b1, 16'hE000, 8'h00, 1'b0, 1, 3);
        bus_cycle("extio_skip01",  CS_EXTIO, 1'b0, 1'b1, 16'hFC00, 8'h00, 1'b1, 0, 1);
        bus_cycle("extio_recover", CS_EXTIO, 1'b0, 1'b1, 16'hFC00, 8'h00, 1'b0, 7, 9);

        // Reset in the middle of a 15-wait EXTIO stall
        bus_cycle("wr_hi_f5_b",    CS_NONE,  1'b0, 1'b0, 16'hFE27, 8'hF5, 1'b0, 0, 2);
        bus_cycle("extio_aborted", CS_EXTIO, 1'b0, 1'b1, 16'hFC00, 8'h00, 1'b0, 15, 17);
        repeat (6) @(negedge CLKX4);
        check("mid_stall_mrdy", int'(MRDY), 0);
        #2 nRESET = 1'b0;
        #1 check("reset_mrdy_immediate", int'(MRDY), 1);
        check("reset_wait_to_mid", int'(WAIT_TO), 0);
        set_bus(CS_NONE, 1'b0, 1'b1, 16'h0000, 8'h00);
        drv_id = 0;
        @(negedge CLKX4);
        #1 nRESET = 1'b1;
        id_q.delete();
        low_q.delete();
        ehi_q.delete();
        name_q.delete();

        bus_cycle("extio_reset_3", CS_EXTIO, 1'b0, 1'b1, 16'hFC00, 8'h00, 1'b0, 3, 5);
        bus_cycle("ext_reset_3",   CS_EXT,   1'b0, 1'b1, 16'hC000, 8'h00, 1'b0, 3, 5);
        bus_cycle("rom_reset_1",   CS_ROM0,  1'b0, 1'b1, 16'hE000, 8'h00, 1'b0, 1, 3);
        bus_cycle("ram_reset_0",   CS_RAM,   1'b0, 1'b1, 16'h1000, 8'h00, 1'b0, 0, 2);
        bus_idle();
        bus_idle();

        check("sb_drain", id_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
